adc_ltc2311_conv_sequencer: RTL and testbench

Conversion sequencer for the LTC2311 ADC interface. It accepts conversion triggers from the PWM and from software, and drives the CNV/SCK pins. It shifts in one 16-bit result per channel from up to CHANNELS parallel SDO lines and presents the captured frame with a one-cycle valid strobe to the AXI register bank. It owns ADC bus sharing between the two trigger sources, one-deep trigger queuing and overrun accounting.

---
 rtl/adc_ltc2311_conv_sequencer.sv | 252 +++++++++++++++++++++++++
 tb/tb_adc_ltc2311_conv_sequencer.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_ltc2311_conv_sequencer.sv
// adc_ltc2311_conv_sequencer
//
// Conversion sequencer for LTC2311 ADCs that share CNV/SCK and have one SDO lane each.
// Arbitrates the PWM and software triggers. Queues at most one trigger while a frame is
// running. Drives CNV, then DATA_WIDTH SCK periods, then publishes the captured frame
// with a one-cycle valid strobe.
//
// Ports
//   ACLK, ARESETN        clock, asynchronous active-low reset
//   cfg_enable           0 ignores new triggers and clears the queued trigger
//   cfg_clk_div          SCK half-period = cfg_clk_div+1 cycles (latched at frame start)
//   cfg_conv_wait        CNV high time   = cfg_conv_wait+1 cycles (latched at frame start)
//   trig_pwm, trig_sw    single-cycle triggers; PWM wins on a tie
//   adc_cnv, adc_sck     ADC control pins (registered)
//   adc_sdo              one serial data lane per channel
//   sample_data          channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   sample_src           source of sample_data: 0 = PWM, 1 = SW
//   sample_valid         one-cycle strobe, coincident with a sample_data update
//   busy                 frame in progress (CONV, SHIFT or DONE)
//   overrun_cnt          saturating dropped-trigger count
//
// Build option: define ADC_LTC2311_SEQ_OVERRUN_CNT_EN to implement the overrun counter.
// Otherwise overrun_cnt is tied to zero.

module adc_ltc2311_conv_sequencer #(
    parameter int unsigned CHANNELS   = 8,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DIV_WIDTH  = 8,
    parameter int unsigned WAIT_WIDTH = 8
) (
    input  logic                           ACLK,
    input  logic                           ARESETN,
    input  logic                           cfg_enable,
    input  logic [DIV_WIDTH-1:0]           cfg_clk_div,
    input  logic [WAIT_WIDTH-1:0]          cfg_conv_wait,
    input  logic                           trig_pwm,
    input  logic                           trig_sw,
    output logic                           adc_cnv,
    output logic                           adc_sck,
    input  logic [CHANNELS-1:0]            adc_sdo,
    output logic [CHANNELS*DATA_WIDTH-1:0] sample_data,
    output logic                           sample_src,
    output logic                           sample_valid,
    output logic                           busy,
    output logic [15:0]                    overrun_cnt
);

    localparam int unsigned HALF_W = $clog2(2 * DATA_WIDTH);
    localparam logic [HALF_W-1:0] LAST_HALF = HALF_W'(2 * DATA_WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StConv, StShift, StDone} state_t;

    state_t                               r_state, w_state_d;
    logic [WAIT_WIDTH-1:0]                r_wait_cnt, w_wait_d;
    logic [DIV_WIDTH-1:0]                 r_div_lat, w_div_lat_d;
    logic [DIV_WIDTH-1:0]                 r_div_cnt, w_div_cnt_d;
    logic [HALF_W-1:0]                    r_half_cnt, w_half_d;
    logic                                 r_cnv, w_cnv_d;
    logic                                 r_sck, w_sck_d;
    logic                                 r_busy, w_busy_d;
    logic                                 r_valid, w_valid_d;
    logic                                 r_src, w_src_d;
    logic                                 r_sample_src, w_sample_src_d;
    logic                                 r_pend, w_pend_d;
    logic                                 r_pend_src, w_pend_src_d;
    logic                                 w_shift_en, w_capture;
    logic                                 w_start, w_start_src;
    logic [CHANNELS-1:0][DATA_WIDTH-1:0]  r_shift;
    logic [CHANNELS*DATA_WIDTH-1:0]       r_data;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d      = r_state;
        w_wait_d       = r_wait_cnt;
        w_div_lat_d    = r_div_lat;
        w_div_cnt_d    = r_div_cnt;
        w_half_d       = r_half_cnt;
        w_cnv_d        = r_cnv;
        w_sck_d        = r_sck;
        w_valid_d      = 1'b0;
        w_src_d        = r_src;
        w_sample_src_d = r_sample_src;
        w_pend_d       = r_pend;
        w_pend_src_d   = r_pend_src;
        w_shift_en     = 1'b0;
        w_capture      = 1'b0;
        w_start        = 1'b0;
        w_start_src    = 1'b0;

        // Trigger arbitration. Anything not started or queued here is an overrun.
        if (!cfg_enable) begin
            w_pend_d = 1'b0;
        end else if (r_state == StIdle) begin
            if (r_pend) begin
                w_start      = 1'b1;
                w_start_src  = r_pend_src;
                w_pend_d     = trig_pwm | trig_sw;
                w_pend_src_d = ~trig_pwm;
            end else if (trig_pwm | trig_sw) begin
                w_start      = 1'b1;
                w_start_src  = ~trig_pwm;
                w_pend_d     = trig_pwm & trig_sw;
                w_pend_src_d = 1'b1;
            end
        end else if (!r_pend && (trig_pwm | trig_sw)) begin
            w_pend_d     = 1'b1;
            w_pend_src_d = ~trig_pwm;
        end

        unique case (r_state)
            StIdle: begin
            end
            StConv: begin
                if (r_wait_cnt == '0) begin
                    w_state_d   = StShift;
                    w_cnv_d     = 1'b0;
                    w_sck_d     = 1'b0;
                    w_div_cnt_d = r_div_lat;
                    w_half_d    = '0;
                end else begin
                    w_wait_d = r_wait_cnt - WAIT_WIDTH'(1);
                end
            end
            StShift: begin
                if (r_div_cnt == '0) begin
                    if (r_half_cnt == LAST_HALF) begin
                        w_state_d      = StDone;
                        w_sck_d        = 1'b0;
                        w_capture      = 1'b1;
                        w_valid_d      = 1'b1;
                        w_sample_src_d = r_src;
                    end else begin
                        w_sck_d     = ~r_sck;
                        w_shift_en  = ~r_sck;  // sample on the edge that raises SCK
                        w_half_d    = r_half_cnt + HALF_W'(1);
                        w_div_cnt_d = r_div_lat;
                    end
                end else begin
                    w_div_cnt_d = r_div_cnt - DIV_WIDTH'(1);
                end
            end
            StDone: begin
                w_state_d = StIdle;
                // Triggers arriving now were judged against the still-set pending flag.
                if (cfg_enable && r_pend) begin
                    w_start     = 1'b1;
                    w_start_src = r_pend_src;
                    w_pend_d    = 1'b0;
                end
            end
            default: w_state_d = StIdle;
        endcase

        if (w_start) begin
            w_state_d   = StConv;
            w_cnv_d     = 1'b1;
            w_wait_d    = cfg_conv_wait;
            w_div_lat_d = cfg_clk_div;
            w_src_d     = w_start_src;
        end

        w_busy_d = (w_state_d != StIdle);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_wait_cnt   <= '0;
            r_div_lat    <= '0;
            r_div_cnt    <= '0;
            r_half_cnt   <= '0;
            r_cnv        <= 1'b0;
            r_sck        <= 1'b0;
            r_busy       <= 1'b0;
            r_valid      <= 1'b0;
            r_src        <= 1'b0;
            r_sample_src <= 1'b0;
            r_pend       <= 1'b0;
            r_pend_src   <= 1'b0;
            r_shift      <= '0;
            r_data       <= '0;
        end else begin
            r_wait_cnt   <= w_wait_d;
            r_div_lat    <= w_div_lat_d;
            r_div_cnt    <= w_div_cnt_d;
            r_half_cnt   <= w_half_d;
            r_cnv        <= w_cnv_d;
            r_sck        <= w_sck_d;
            r_busy       <= w_busy_d;
            r_valid      <= w_valid_d;
            r_src        <= w_src_d;
            r_sample_src <= w_sample_src_d;
            r_pend       <= w_pend_d;
            r_pend_src   <= w_pend_src_d;
            if (w_shift_en) begin
                for (int i = 0; i < int'(CHANNELS); i++) begin
                    r_shift[i] <= {r_shift[i][DATA_WIDTH-2:0], adc_sdo[i]};
                end
            end
            if (w_capture) begin
                r_data <= r_shift;
            end
        end
    end

`ifdef ADC_LTC2311_SEQ_OVERRUN_CNT_EN
    logic [1:0]  w_drops;
    logic [16:0] w_ovr_sum;
    logic [15:0] r_ovr_cnt;

    // Mirrors the arbitration above: count every trigger that was neither started nor queued.
    always_comb begin
        w_drops = 2'd0;
        if (cfg_enable) begin
            if (r_state != StIdle && r_pend) begin
                w_drops = {1'b0, trig_pwm} + {1'b0, trig_sw};
            end else if ((r_state != StIdle || r_pend) && trig_pwm && trig_sw) begin
                w_drops = 2'd1;
            end
        end
        w_ovr_sum = {1'b0, r_ovr_cnt} + {15'd0, w_drops};
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_ovr_cnt <= '0;
        end else if (w_ovr_sum[16]) begin
            r_ovr_cnt <= 16'hFFFF;
        end else begin
            r_ovr_cnt <= w_ovr_sum[15:0];
        end
    end

    assign overrun_cnt = r_ovr_cnt;
`else
    assign overrun_cnt = 16'd0;
`endif

    assign adc_cnv      = r_cnv;
    assign adc_sck      = r_sck;
    assign busy         = r_busy;
    assign sample_valid = r_valid;
    assign sample_src   = r_sample_src;
    assign sample_data  = r_data;

endmodule

// File: tb/tb_adc_ltc2311_conv_sequencer.sv
module tb_adc_ltc2311_conv_sequencer;

    localparam int CH   = 8;
    localparam int DW   = 16;
    localparam int MAXC = 400;

    logic              ACLK = 1'b0;
    logic              ARESETN;
    logic              cfg_enable;
    logic [7:0]        cfg_clk_div;
    logic [7:0]        cfg_conv_wait;
    logic              trig_pwm;
    logic              trig_sw;
    logic              adc_cnv;
    logic              adc_sck;
    logic [CH-1:0]     adc_sdo = '0;
    logic [CH*DW-1:0]  sample_data;
    logic              sample_src;
    logic              sample_valid;
    logic              busy;
    logic [15:0]       overrun_cnt;

    adc_ltc2311_conv_sequencer #(
        .CHANNELS  (CH),
        .DATA_WIDTH(DW),
        .DIV_WIDTH (8),
        .WAIT_WIDTH(8)
    ) dut (
        .ACLK         (ACLK),
        .ARESETN      (ARESETN),
        .cfg_enable   (cfg_enable),
        .cfg_clk_div  (cfg_clk_div),
        .cfg_conv_wait(cfg_conv_wait),
        .trig_pwm     (trig_pwm),
        .trig_sw      (trig_sw),
        .adc_cnv      (adc_cnv),
        .adc_sck      (adc_sck),
        .adc_sdo      (adc_sdo),
        .sample_data  (sample_data),
        .sample_src   (sample_src),
        .sample_valid (sample_valid),
        .busy         (busy),
        .overrun_cnt  (overrun_cnt)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_ovr  = 0;

    // Scoreboard of expected frames, popped on every sample_valid
    typedef struct {
        logic             src;
        logic [CH*DW-1:0] data;
    } exp_t;
    exp_t sb_q[$];
    bit   sb_ignore = 1'b0;

    // ADC model: present MSB first, advance after each observed SCK rise
    logic [DW-1:0] sdo_words[CH];
    int            sdo_idx  = 0;
    logic          prev_sck = 1'b0;

    always @(negedge ACLK) begin
        if (adc_cnv === 1'b1) sdo_idx = 0;
        else if (adc_sck === 1'b1 && prev_sck === 1'b0 && sdo_idx < DW) sdo_idx++;
        prev_sck = adc_sck;
        for (int c = 0; c < CH; c++)
            adc_sdo[c] = (sdo_idx < DW) ? sdo_words[c][DW-1-sdo_idx] : 1'b0;
    end

    always @(negedge ACLK) begin
        exp_t e;
        if (sample_valid === 1'b1 && !sb_ignore) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL sb_unexpected_valid: got sample_valid=1 src=%0b, required no frame",
                         sample_src);
            end else begin
                n_pass++;
                e = sb_q.pop_front();
                n_checks++;
                if (sample_data !== e.data)
                    $display("FAIL sb_data: got %h, required %h", sample_data, e.data);
                else n_pass++;
                n_checks++;
                if (sample_src !== e.src)
                    $display("FAIL sb_src: got %0b, required %0b", sample_src, e.src);
                else n_pass++;
            end
        end
    end

    // Per-cycle stimulus table and observation log (cycle 0 = trigger cycle)
    bit   stim_pwm[MAXC+1];
    bit   stim_sw[MAXC+1];
    bit   stim_en[MAXC+1];
    logic log_cnv[MAXC+1];
    logic log_sck[MAXC+1];
    logic log_valid[MAXC+1];
    logic log_busy[MAXC+1];

    task automatic clear_stim();
        for (int k = 0; k <= MAXC; k++) begin
            stim_pwm[k] = 1'b0;
            stim_sw[k]  = 1'b0;
            stim_en[k]  = 1'b1;
        end
    endtask

    task automatic run_cycles(input int n);
        log_cnv[0]   = adc_cnv;
        log_sck[0]   = adc_sck;
        log_valid[0] = sample_valid;
        log_busy[0]  = busy;
        for (int k = 0; k < n; k++) begin
            trig_pwm   = stim_pwm[k];
            trig_sw    = stim_sw[k];
            cfg_enable = stim_en[k];
            @(posedge ACLK);
            #1;
            log_cnv[k+1]   = adc_cnv;
            log_sck[k+1]   = adc_sck;
            log_valid[k+1] = sample_valid;
            log_busy[k+1]  = busy;
        end
        trig_pwm = 1'b0;
        trig_sw  = 1'b0;
    endtask

    // sel: 0 cnv, 1 sck, 2 valid, 3 busy
    function automatic logic log_at(input int sel, input int k);
        case (sel)
            0:       return log_cnv[k];
            1:       return log_sck[k];
            2:       return log_valid[k];
            default: return log_busy[k];
        endcase
    endfunction

    function automatic int rises(input int sel, input int n);
        int r = 0;
        for (int k = 1; k <= n; k++)
            if (log_at(sel, k) === 1'b1 && log_at(sel, k-1) !== 1'b1) r++;
        return r;
    endfunction

    function automatic int highs(input int sel, input int n);
        int r = 0;
        for (int k = 1; k <= n; k++) if (log_at(sel, k) === 1'b1) r++;
        return r;
    endfunction

    // nth (1-based) high cycle, -1 if absent
    function automatic int nth_high(input int sel, input int n, input int nth);
        int seen = 0;
        for (int k = 1; k <= n; k++)
            if (log_at(sel, k) === 1'b1) begin
                seen++;
                if (seen == nth) return k;
            end
        return -1;
    endfunction

    function automatic int last_high(input int sel, input int n);
        int r = -1;
        for (int k = 1; k <= n; k++) if (log_at(sel, k) === 1'b1) r = k;
        return r;
    endfunction

    function automatic logic [CH*DW-1:0] pack_words();
        logic [CH*DW-1:0] r;
        for (int c = 0; c < CH; c++) r[c*DW +: DW] = sdo_words[c];
        return r;
    endfunction

    task automatic push_exp(input logic src);
        exp_t e;
        e.src  = src;
        e.data = pack_words();
        sb_q.push_back(e);
    endtask

    task automatic check_int(input string name, input int got, input int req);
        n_checks++;
        if (got !== req) $display("FAIL %s: got %0d, required %0d", name, got, req);
        else n_pass++;
    endtask

    task automatic test_reset();
        ARESETN = 1'b0; cfg_enable = 1'b1; cfg_clk_div = 8'd0; cfg_conv_wait = 8'd9;
        trig_pwm = 1'b0; trig_sw = 1'b0;
        #12;
        check_int("rst_cnv", int'(adc_cnv), 0);
        check_int("rst_sck", int'(adc_sck), 0);
        check_int("rst_busy", int'(busy), 0);
        check_int("rst_valid", int'(sample_valid), 0);
        check_int("rst_src", int'(sample_src), 0);
        check_int("rst_ovr", int'(overrun_cnt), 0);
        n_checks++;
        if (sample_data !== '0) $display("FAIL rst_data: got %h, required 0", sample_data);
        else n_pass++;
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
    endtask

    task automatic test_single_frame();
        cfg_clk_div = 8'd0; cfg_conv_wait = 8'd9;
        for (int c = 0; c < CH; c++) sdo_words[c] = 16'h3C00 + 16'(c * 16'h0111);
        sdo_words[0] = 16'hA5C3;
        sdo_words[7] = 16'h0001;
        push_exp(1'b0);
        clear_stim();
        stim_pwm[0] = 1'b1;
        run_cycles(50);
        check_int("single_cnv_first", nth_high(0, 50, 1), 1);
        check_int("single_cnv_last", last_high(0, 50), 10);
        check_int("single_cnv_len", highs(0, 50), 10);
        check_int("single_sck_pulses", rises(1, 50), 16);
        check_int("single_valid_cycle", nth_high(2, 50, 1), 43);
        check_int("single_valid_count", highs(2, 50), 1);
        check_int("single_busy_first", nth_high(3, 50, 1), 1);
        check_int("single_busy_last", last_high(3, 50), 43);
        check_int("single_sb_empty", sb_q.size(), 0);
    endtask

    task automatic test_simultaneous();
        int v1;
        for (int c = 0; c < CH; c++) sdo_words[c] = 16'h5A00 ^ 16'(c * 16'h1357);
        push_exp(1'b0);
        push_exp(1'b1);
        clear_stim();
        stim_pwm[0] = 1'b1;
        stim_sw[0]  = 1'b1;
        run_cycles(100);
        v1 = nth_high(2, 100, 1);
        check_int("simul_first_valid", v1, 43);
        check_int("simul_cnv_in_done", (v1 > 0) ? int'(log_cnv[v1]) : -1, 0);
        check_int("simul_cnv_after_done", (v1 > 0) ? int'(log_cnv[v1+1]) : -1, 1);
        check_int("simul_second_valid", nth_high(2, 100, 2), 86);
        check_int("simul_cnv_frames", rises(0, 100), 2);
        check_int("simul_ovr", int'(overrun_cnt), exp_ovr);
        check_int("simul_sb_empty", sb_q.size(), 0);
    endtask

    task automatic test_three_sw();
        for (int c = 0; c < CH; c++) sdo_words[c] = 16'hFFFF - 16'(c * 16'h0F1E);
        push_exp(1'b1);
        push_exp(1'b1);
        clear_stim();
        stim_sw[0]  = 1'b1;
        stim_sw[5]  = 1'b1;
        stim_sw[15] = 1'b1;
        stim_sw[25] = 1'b1;
`ifdef ADC_LTC2311_SEQ_OVERRUN_CNT_EN
        exp_ovr += 2;
`endif
        run_cycles(100);
        check_int("three_sw_frames", rises(0, 100), 2);
        check_int("three_sw_valids", highs(2, 100), 2);
        check_int("three_sw_ovr", int'(overrun_cnt), exp_ovr);
        check_int("three_sw_sb_empty", sb_q.size(), 0);
    endtask

    task automatic test_enable_drop();
        for (int c = 0; c < CH; c++) sdo_words[c] = 16'h0F0F + 16'(c << 12);
        push_exp(1'b0);
        clear_stim();
        stim_pwm[0] = 1'b1;
        stim_sw[3]  = 1'b1;
        for (int k = 20; k <= MAXC; k++) stim_en[k] = 1'b0;
        stim_pwm[60] = 1'b1;
        stim_sw[70]  = 1'b1;
        stim_sw[71]  = 1'b1;
        stim_pwm[71] = 1'b1;
        run_cycles(100);
        check_int("endrop_cnv_frames", rises(0, 100), 1);
        check_int("endrop_valid_cycle", nth_high(2, 100, 1), 43);
        check_int("endrop_valid_count", highs(2, 100), 1);
        check_int("endrop_busy_end", int'(log_busy[100]), 0);
        check_int("endrop_ovr", int'(overrun_cnt), exp_ovr);
        check_int("endrop_sb_empty", sb_q.size(), 0);
        cfg_enable = 1'b1;
    endtask

`ifdef ADC_LTC2311_SEQ_OVERRUN_CNT_EN
    task automatic test_saturation();
        int guard = 0;
        sb_ignore     = 1'b1;
        cfg_enable    = 1'b1;
        cfg_clk_div   = 8'h3F;
        cfg_conv_wait = 8'h3F;
        // Two triggers per cycle: well over 0x10005 triggers, nearly all dropped
        trig_pwm = 1'b1;
        trig_sw  = 1'b1;
        for (int k = 0; k < 32'h8040; k++) begin
            @(posedge ACLK);
            #1;
        end
        trig_pwm = 1'b0;
        trig_sw  = 1'b0;
        while (busy !== 1'b0 && guard < 10000) begin
            @(negedge ACLK);
            guard++;
        end
        check_int("sat_drain_idle", int'(busy), 0);
        check_int("sat_ovr", int'(overrun_cnt), 16'hFFFF);
        @(negedge ACLK);
        sb_ignore = 1'b0;
    endtask
`endif

    task automatic test_reset_mid_shift();
        int guard   = 0;
        int v_seen  = 0;
        cfg_clk_div   = 8'd3;
        cfg_conv_wait = 8'd9;
        for (int c = 0; c < CH; c++) sdo_words[c] = 16'h1111 * 16'(c + 1);
        @(negedge ACLK);
        trig_pwm = 1'b1;
        @(negedge ACLK);
        trig_pwm = 1'b0;
        while (adc_sck !== 1'b1 && guard < 100) begin
            @(negedge ACLK);
            guard++;
        end
        check_int("rstmid_reached_sck_high", int'(adc_sck), 1);
        ARESETN = 1'b0;
        #1;
        check_int("rstmid_sck_low", int'(adc_sck), 0);
        check_int("rstmid_cnv_low", int'(adc_cnv), 0);
        check_int("rstmid_busy", int'(busy), 0);
        check_int("rstmid_ovr_clear", int'(overrun_cnt), 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge ACLK);
            if (sample_valid !== 1'b0) v_seen++;
        end
        ARESETN = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge ACLK);
            if (sample_valid !== 1'b0) v_seen++;
        end
        check_int("rstmid_no_valid", v_seen, 0);

        exp_ovr = 0;
        for (int c = 0; c < CH; c++) sdo_words[c] = 16'hC0DE ^ 16'(c * 16'h2222);
        push_exp(1'b1);
        clear_stim();
        stim_sw[0] = 1'b1;
        run_cycles(150);
        check_int("postrst_cnv_len", highs(0, 150), 10);
        check_int("postrst_sck_pulses", rises(1, 150), 16);
        check_int("postrst_valid_cycle", nth_high(2, 150, 1), 139);
        check_int("postrst_sb_empty", sb_q.size(), 0);
    endtask

    initial begin
        for (int c = 0; c < CH; c++) sdo_words[c] = '0;
        test_reset();
        test_single_frame();
        test_simultaneous();
        test_three_sw();
        test_enable_drop();
`ifdef ADC_LTC2311_SEQ_OVERRUN_CNT_EN
        test_saturation();
`endif
        test_reset_mid_shift();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
